// File: rtl/vga_pkg.sv
// Shared 640x480@72 Hz timing constants and scheduler state encoding.
// Used by the sync generator and by the vblank update scheduler.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 24;
    localparam int H_SYNC    = 40;
    localparam int H_BACK    = 128;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 9;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 28;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

endpackage

// File: rtl/vblank_update_scheduler_if.sv
// req/grant/done handshake between the scheduler (master) and the game engines (slave).
interface vblank_update_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;

    modport master (input req, input done, output grant);
    modport slave  (output req, output done, input grant);
endinterface

// File: rtl/lsb_priority_picker.sv
// Combinational pick of the lowest set bit of a mask, as one-hot, plus an any-set flag.
module lsb_priority_picker #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_onehot,
    output logic             o_any
);
    always_comb begin
        o_onehot = i_mask & (~i_mask + WIDTH'(1));
        o_any    = |i_mask;
    end
endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants one update slot per requesting game engine during vertical blanking,
// plus frame counter, divided game tick and sticky overrun/timeout flags.
module vblank_update_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int TIMEOUT   = 1023,
    parameter int TICK_DIV  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 enable,
    input  logic                 clear_err,
    vblank_update_scheduler_if.master bus,
    output logic                 frame_start,
    output logic                 game_tick,
    output logic                 vblank,
    output logic                 busy,
    output logic [7:0]           frame_count,
    output logic                 overrun,
    output logic [NUM_REQ-1:0]   timeout_err
);
    import vga_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (H_DISPLAY < 1 || V_DISPLAY < 1 || TIMEOUT < 1 || TICK_DIV < 1 || NUM_REQ < 1) begin : g_bad_params
        $error("vblank_update_scheduler: invalid parameter set");
    end

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_grant;
    logic [TW-1:0]      r_timer;
    logic [DW-1:0]      r_div;
    logic               r_frame_start;
    logic               r_game_tick;
    logic [7:0]         r_frame_count;
    logic               r_overrun;
    logic [NUM_REQ-1:0] r_timeout_err;

    logic               w_trigger;
    logic               w_wrap;
    logic               w_done_hit;
    logic               w_to_hit;
    logic               w_ovr_set;
    logic [NUM_REQ-1:0] w_to_set;
    logic [NUM_REQ-1:0] w_pick;
    logic               w_pick_any;

    lsb_priority_picker #(.WIDTH(NUM_REQ)) u_pick (
        .i_mask   (r_pending),
        .o_onehot (w_pick),
        .o_any    (w_pick_any)
    );

    // A trigger while still sequencing is treated like a frame wrap: abort, flag, restart.
    always_comb begin
        w_trigger  = (vpos == 10'(V_DISPLAY)) && (hpos == '0);
        w_wrap     = (vpos == '0) && (hpos == '0);
        w_done_hit = |(bus.done & r_grant);
        w_to_hit   = (r_state == ST_GRANT) && !w_done_hit && (r_timer == TW'(TIMEOUT - 1));
        w_ovr_set  = (w_trigger || w_wrap) && (r_state != ST_IDLE);
        w_to_set   = (w_to_hit && !w_ovr_set) ? r_grant : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_grant       <= '0;
            r_timer       <= '0;
            r_div         <= '0;
            r_frame_start <= 1'b0;
            r_game_tick   <= 1'b0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= '0;
        end else begin
            r_frame_start <= w_trigger;
            r_game_tick   <= w_trigger && (r_div == '0);
            if (w_trigger) begin
                r_frame_count <= r_frame_count + 8'd1;
                r_div         <= (r_div == DW'(TICK_DIV - 1)) ? '0 : r_div + DW'(1);
            end
            r_overrun     <= (r_overrun && !clear_err) || w_ovr_set;
            r_timeout_err <= (r_timeout_err & ~{NUM_REQ{clear_err}}) | w_to_set;

            if (w_trigger) begin
                r_pending <= bus.req & {NUM_REQ{enable}};
                r_grant   <= '0;
                r_state   <= ST_SCAN;
            end else if (w_wrap && r_state != ST_IDLE) begin
                r_pending <= '0;
                r_grant   <= '0;
                r_state   <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_pick_any) begin
                            r_grant <= w_pick;
                            r_timer <= '0;
                            r_state <= ST_GRANT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_GRANT: begin
                        r_timer <= r_timer + TW'(1);
                        if (w_done_hit || w_to_hit) begin
                            r_grant   <= '0;
                            r_pending <= r_pending & ~r_grant;
                            r_state   <= ST_SCAN;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.grant   = r_grant;
    assign frame_start = r_frame_start;
    assign game_tick   = r_game_tick;
    assign frame_count = r_frame_count;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != ST_IDLE);
    assign vblank      = (vpos >= 10'(V_DISPLAY));

endmodule
